mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory arbiter downstream of the core's instruction-cache refill port and data-cache port. It merges instruction refills, data refills and stores onto one single-outstanding external bus with a req/ack handshake. Stores are absorbed by a posted write buffer so the core's memory stage never waits on a write. Data reads are ordered behind all buffered writes; the core is stalled only when the buffer is full.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WBUF_DEPTH, 4, write-buffer entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive non-instruction grants tolerated while an instruction refill waits
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_iaddr  in  ADDR_W  instruction refill address
- i_iread_en  in  1  instruction refill request (level, held until served)
- o_inst  out  DATA_W  refill data, valid with o_iread_vd
- o_iread_vd  out  1  one-cycle refill-done pulse
- i_memaddr  in  ADDR_W  data address (read and write)
- i_read_en  in  1  data refill request (level)
- o_read_data  out  DATA_W  data, valid with o_read_vd
- o_read_vd  out  1  one-cycle data-done pulse
- i_write_en  in  1  store strobe, one cycle per store
- i_write_data  in  DATA_W  store data
- o_stall  out  1  combinational: i_write_en && buffer full
- o_bus_req, o_bus_we  out  1  bus request / write qualifier
- o_bus_addr, o_bus_wdata  out  ADDR_W/DATA_W  bus address/data, stable while o_bus_req
- i_bus_ack  in  1  bus completion, sampled on rising edge
- i_bus_rdata  in  DATA_W  read data, valid with i_bus_ack

## Operation
- Write buffer: push {i_memaddr, i_write_data} when i_write_en && !full; when full, entry dropped and o_stall asserted (core must hold). Pop on write ack. Push and pop in the same cycle allowed when not full.
- FSM states IDLE, BUSY, RESP.
- IDLE: select per priority and register the bus request; transition to BUSY.
  - Priority: instruction if i_iread_en && starve_cnt==STARVE_MAX; else buffer head if non-empty; else data read if i_read_en; else instruction.
  - Data read never issues while buffer non-empty (read-after-write ordering).
  - Instruction reads may bypass buffered writes (no self-modifying-code ordering).
- BUSY: outputs held. On i_bus_ack:
  - Write: pop; next IDLE.
  - Read: capture i_bus_rdata into o_inst or o_read_data; next RESP.
- RESP: pulse matching vd for one cycle; no launch; next IDLE. Gives the cache one cycle to fill so the stale level request is not re-served.
- starve_cnt: saturating; cleared on instruction grant or !i_iread_en; incremented on any other grant while i_iread_en.
- Reset: all outputs 0, FSM IDLE, buffer empty, counter 0. Asynchronous assertion mid-BUSY drops o_bus_req immediately; any later ack is ignored in IDLE.

## Timing
- Request seen in IDLE at cycle t → o_bus_req high at t+1.
- Ack at edge k → read vd pulse at cycle k+1, IDLE at k+2; minimum read turnaround 3 cycles (t+1 req/ack, t+2 vd, t+3 next req).
- Write: ack at edge k → IDLE at k+1, next req at k+2.
- o_stall purely combinational, same cycle as i_write_en.
- o_inst / o_read_data hold last captured value between pulses.
- Ack in IDLE or RESP is ignored.

## Structure
- Package mem_arb_pkg: state enum (IDLE/BUSY/RESP), source enum (SRC_INST/SRC_DREAD/SRC_WRITE), default parameter constants.
- Sub-module wbuf: synchronous FIFO with full/empty flags and pointer wrap via extra MSB. Arbiter FSM and starvation counter stay in mem_arbiter.

## Test plan
- Instruction refill i_iaddr=0x100, bus acks with 0x00000013 two cycles after req: o_bus_req t+1, o_inst=0x13 with o_iread_vd one cycle after ack, exactly one pulse.
- Stores to 0x200/0x204 followed by read of 0x200: bus order write 0x200, write 0x204, then read; o_read_vd only after both writes acked.
- Four back-to-back stores with bus never acking (WBUF_DEPTH=4): fifth i_write_en raises o_stall in the same cycle; first ack lowers it and the retried store is accepted.
- Continuous stores plus pending instruction refill (STARVE_MAX=4): instruction granted after exactly 4 write grants.
- Assert rst while BUSY: o_bus_req drops asynchronously; buffer empty; following ack produces no vd pulse.
- Simultaneous i_iread_en and i_read_en with empty buffer and starve_cnt=0: data served first, then instruction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory arbiter slice.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_WBUF_DEPTH = 4;
    localparam int DEF_STARVE_MAX = 4;

    // Arbiter FSM states; the encoding is also what the debug state port shows.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Who owns the single outstanding bus transaction.
    typedef enum logic [1:0] {
        SRC_INST  = 2'd0,
        SRC_DREAD = 2'd1,
        SRC_WRITE = 2'd2
    } src_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// External memory bus between the arbiter (master) and the memory (slave).
//
// Handshake: the master raises o_bus_req together with a stable o_bus_addr,
// o_bus_we and o_bus_wdata, and holds all of them unchanged until it samples
// i_bus_ack high on a rising edge. That edge completes the transfer; for reads
// i_bus_rdata is valid in the same cycle as i_bus_ack. Only one transfer is
// ever outstanding, and i_bus_ack seen without a pending request is ignored.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              o_bus_req;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_wdata;
    logic              i_bus_ack;
    logic [DATA_W-1:0] i_bus_rdata;

    modport master (
        output o_bus_req,
        output o_bus_we,
        output o_bus_addr,
        output o_bus_wdata,
        input  i_bus_ack,
        input  i_bus_rdata
    );

    modport slave (
        input  o_bus_req,
        input  o_bus_we,
        input  o_bus_addr,
        input  o_bus_wdata,
        output i_bus_ack,
        output i_bus_rdata
    );
endinterface

// File: rtl/mem_arbiter_wbuf.sv
// Posted write buffer: synchronous FIFO, pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter.
module mem_arbiter_wbuf
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
    parameter int DEPTH = DEF_WBUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is dropped; the caller stalls the core instead.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head    = mem[rd_ptr[PW-1:0]];

    // Advance read/write pointers on accepted push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction refills, data refills and buffered stores onto one
// single-outstanding external bus. Stores are posted into a write buffer so
// the core only stalls when that buffer is full.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_iaddr,
    input  logic              i_iread_en,
    output logic [DATA_W-1:0] o_inst,
    output logic              o_iread_vd,
    input  logic [ADDR_W-1:0] i_memaddr,
    input  logic              i_read_en,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_read_vd,
    input  logic              i_write_en,
    input  logic [DATA_W-1:0] i_write_data,
    output logic              o_stall,
    output logic [1:0]        o_state,
    mem_arbiter_if.master     bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_RESP = RESP;

    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

    logic [1:0]               state;
    src_e                     src;
    logic [CW-1:0]            starve_cnt;

    logic                     wb_full;
    logic                     wb_empty;
    logic                     wb_pop;
    logic [ADDR_W+DATA_W-1:0] wb_head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;

    logic                     grant;
    src_e                     grant_src;
    logic                     bus_done;

    assign head_addr = wb_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data = wb_head[DATA_W-1:0];
    assign o_stall   = i_write_en && wb_full;
    assign o_state   = state;
    assign bus_done  = (state == ST_BUSY) && bus.i_bus_ack;
    assign wb_pop    = bus_done && (src == SRC_WRITE);

    mem_arbiter_wbuf #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (i_write_en),
        .push_data ({i_memaddr, i_write_data}),
        .pop       (wb_pop),
        .head      (wb_head),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    // Pick the next bus owner while idle; data reads wait behind buffered
    // writes, instruction refills may bypass them.
    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_INST;
        if (state == ST_IDLE) begin
            if (i_iread_en && (starve_cnt == STARVE_TOP)) begin
                grant     = 1'b1;
                grant_src = SRC_INST;
            end else if (!wb_empty) begin
                grant     = 1'b1;
                grant_src = SRC_WRITE;
            end else if (i_read_en) begin
                grant     = 1'b1;
                grant_src = SRC_DREAD;
            end else if (i_iread_en) begin
                grant     = 1'b1;
                grant_src = SRC_INST;
            end
        end
    end

    // Arbiter FSM and registered bus request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            src             <= SRC_INST;
            bus.o_bus_req   <= 1'b0;
            bus.o_bus_we    <= 1'b0;
            bus.o_bus_addr  <= '0;
            bus.o_bus_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state         <= ST_BUSY;
                        src           <= grant_src;
                        bus.o_bus_req <= 1'b1;
                        bus.o_bus_we  <= (grant_src == SRC_WRITE);
                        case (grant_src)
                            SRC_WRITE: begin
                                bus.o_bus_addr  <= head_addr;
                                bus.o_bus_wdata <= head_data;
                            end
                            SRC_DREAD: begin
                                bus.o_bus_addr  <= i_memaddr;
                                bus.o_bus_wdata <= '0;
                            end
                            default: begin
                                bus.o_bus_addr  <= i_iaddr;
                                bus.o_bus_wdata <= '0;
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (bus.i_bus_ack) begin
                        bus.o_bus_req <= 1'b0;
                        bus.o_bus_we  <= 1'b0;
                        state         <= (src == SRC_WRITE) ? ST_IDLE : ST_RESP;
                    end
                end
                // One dead cycle lets the cache fill so its level request drops.
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture read data and produce the one-cycle done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_inst      <= '0;
            o_read_data <= '0;
            o_iread_vd  <= 1'b0;
            o_read_vd   <= 1'b0;
        end else begin
            o_iread_vd <= 1'b0;
            o_read_vd  <= 1'b0;
            if (bus_done && (src == SRC_INST)) begin
                o_inst     <= bus.i_bus_rdata;
                o_iread_vd <= 1'b1;
            end
            if (bus_done && (src == SRC_DREAD)) begin
                o_read_data <= bus.i_bus_rdata;
                o_read_vd   <= 1'b1;
            end
        end
    end

    // Count non-instruction grants while an instruction refill is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!i_iread_en) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_src == SRC_INST)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_TOP)
                starve_cnt <= starve_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SMAX  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic [AW-1:0] i_iaddr      = '0;
    logic          i_iread_en   = 1'b0;
    logic [DW-1:0] o_inst;
    logic          o_iread_vd;
    logic [AW-1:0] i_memaddr    = '0;
    logic          i_read_en    = 1'b0;
    logic [DW-1:0] o_read_data;
    logic          o_read_vd;
    logic          i_write_en   = 1'b0;
    logic [DW-1:0] i_write_data = '0;
    logic          o_stall;
    logic [1:0]    o_state;

    logic          ack   = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          o_bus_req;
    logic          o_bus_we;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_wdata;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.i_bus_ack   = ack;
    assign bus.i_bus_rdata = rdata;
    assign o_bus_req       = bus.o_bus_req;
    assign o_bus_we        = bus.o_bus_we;
    assign o_bus_addr      = bus.o_bus_addr;
    assign o_bus_wdata     = bus.o_bus_wdata;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_iaddr(i_iaddr), .i_iread_en(i_iread_en),
        .o_inst(o_inst), .o_iread_vd(o_iread_vd),
        .i_memaddr(i_memaddr), .i_read_en(i_read_en),
        .o_read_data(o_read_data), .o_read_vd(o_read_vd),
        .i_write_en(i_write_en), .i_write_data(i_write_data),
        .o_stall(o_stall), .o_state(o_state),
        .bus(bus)
    );

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit ack_hold   = 1'b0;
    int ack_delay  = 0;
    int force_req  = 0;
    int force_done = 0;
    int age        = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        forever begin
            @(posedge clk); #2;
            ack = 1'b0;
            if (force_req != force_done) begin
                ack        = 1'b1;
                rdata      = 32'hDEAD_BEEF;
                force_done = force_req;
            end else if (o_bus_req && !ack_hold) begin
                if (age >= ack_delay) begin
                    ack   = 1'b1;
                    rdata = mem_word(o_bus_addr);
                    age   = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    // exp_q holds the stores still owed to the bus, oldest first, as {addr, data}.
    logic [63:0] exp_q[$];
    int          m_stage  = 0;  // 0 bus free, 1 waiting for ack, 2 response cycle
    int          m_kind   = 0;  // 0 instruction, 1 data read, 2 write
    int          m_starve = 0;
    logic        m_req = 1'b0, m_we = 1'b0, m_ivd = 1'b0, m_rvd = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_inst = '0, m_rdata = '0;
    int          depth_before;
    int          pick;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                m_stage = 0; m_kind = 0; m_starve = 0;
                m_req = 1'b0; m_we = 1'b0; m_ivd = 1'b0; m_rvd = 1'b0;
                m_addr = '0; m_wdata = '0; m_inst = '0; m_rdata = '0;
            end else begin
                depth_before = exp_q.size();
                pick  = -1;
                m_ivd = 1'b0;
                m_rvd = 1'b0;
                if (m_stage == 2) begin
                    m_stage = 0;
                end else if (m_stage == 1) begin
                    if (ack) begin
                        m_req = 1'b0;
                        m_we  = 1'b0;
                        if (m_kind == 2) begin
                            void'(exp_q.pop_front());
                            m_stage = 0;
                        end else begin
                            m_stage = 2;
                            if (m_kind == 0) begin m_inst = rdata; m_ivd = 1'b1; end
                            else begin m_rdata = rdata; m_rvd = 1'b1; end
                        end
                    end
                end else begin
                    if (i_iread_en && m_starve == SMAX) pick = 0;
                    else if (depth_before > 0)         pick = 2;
                    else if (i_read_en)                pick = 1;
                    else if (i_iread_en)               pick = 0;
                    if (pick >= 0) begin
                        m_stage = 1;
                        m_kind  = pick;
                        m_req   = 1'b1;
                        m_we    = (pick == 2);
                        if (pick == 2) begin
                            m_addr  = exp_q[0][63:32];
                            m_wdata = exp_q[0][31:0];
                        end else if (pick == 1) begin
                            m_addr = i_memaddr;
                        end else begin
                            m_addr = i_iaddr;
                        end
                    end
                end
                if (!i_iread_en)                   m_starve = 0;
                else if (pick == 0)                m_starve = 0;
                else if (pick > 0 && m_starve < SMAX) m_starve++;
                if (i_write_en && depth_before < DEPTH)
                    exp_q.push_back({i_memaddr, i_write_data});
            end
        end
    end

    // ---------------- compare process + grant log ----------------
    logic        gl_we[$];
    logic [31:0] gl_addr[$];
    int          ivd_cnt  = 0;
    int          rvd_cnt  = 0;
    logic        prev_req = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            chk("bus_req", o_bus_req, m_req);
            if (m_req) begin
                chk("bus_addr", o_bus_addr, m_addr);
                chk("bus_we", o_bus_we, m_we);
                if (m_we) chk("bus_wdata", o_bus_wdata, m_wdata);
            end
            chk("iread_vd", o_iread_vd, m_ivd);
            chk("read_vd", o_read_vd, m_rvd);
            chk("inst", o_inst, m_inst);
            chk("read_data", o_read_data, m_rdata);
            chk("stall", o_stall, i_write_en && (exp_q.size() == DEPTH));
            if (o_bus_req && !prev_req) begin
                gl_we.push_back(o_bus_we);
                gl_addr.push_back(o_bus_addr);
            end
            prev_req = o_bus_req;
            if (o_iread_vd) ivd_cnt++;
            if (o_read_vd)  rvd_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        gl_we.delete();
        gl_addr.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    int base;
    bit got, gi, gr, stalled, di, dr;
    int n;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_req", o_bus_req, 0);
        chk("rst_we", o_bus_we, 0);
        chk("rst_addr", o_bus_addr, 0);
        chk("rst_ivd", o_iread_vd, 0);
        chk("rst_rvd", o_read_vd, 0);
        chk("rst_inst", o_inst, 0);
        chk("rst_rdata", o_read_data, 0);
        step();
        rst = 1'b0;
        idle_wait(2);

        // 1: instruction refill, ack two cycles after request
        @(negedge clk); ack_delay = 1;
        base = ivd_cnt;
        step();
        i_iaddr = 32'h100; i_iread_en = 1'b1;
        @(negedge clk); chk("t1_req_same_cycle", o_bus_req, 0);
        @(negedge clk); chk("t1_req_next", o_bus_req, 1); chk("t1_addr", o_bus_addr, 32'h100);
        chk("t1_we", o_bus_we, 0);
        @(negedge clk); chk("t1_req_held", o_bus_req, 1);
        @(negedge clk); chk("t1_ivd", o_iread_vd, 1); chk("t1_inst", o_inst, 32'h13);
        chk("t1_req_low", o_bus_req, 0);
        step();
        i_iread_en = 1'b0;
        idle_wait(6);
        chk("t1_one_pulse", ivd_cnt - base, 1);
        chk("t1_inst_hold", o_inst, 32'h13);

        // 2: two stores then a read of the first address
        @(negedge clk); ack_delay = 0;
        clear_log();
        step(); i_write_en = 1'b1; i_memaddr = 32'h200; i_write_data = 32'hAAAA_0001;
        step(); i_memaddr = 32'h204; i_write_data = 32'hAAAA_0002;
        step(); i_write_en = 1'b0; i_memaddr = 32'h200; i_read_en = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (o_read_vd) got = 1'b1;
        end
        chk("t2_rvd_seen", got, 1);
        chk("t2_grants_before_vd", gl_addr.size(), 3);
        step(); i_read_en = 1'b0;
        idle_wait(4);
        chk("t2_grants", gl_addr.size(), 3);
        if (gl_addr.size() >= 3) begin
            chk("t2_g0_addr", gl_addr[0], 32'h200); chk("t2_g0_we", gl_we[0], 1);
            chk("t2_g1_addr", gl_addr[1], 32'h204); chk("t2_g1_we", gl_we[1], 1);
            chk("t2_g2_addr", gl_addr[2], 32'h200); chk("t2_g2_we", gl_we[2], 0);
        end
        chk("t2_rdata", o_read_data, 32'h5A5A_0200);

        // 3: fill the buffer with the bus stalled, fifth store stalls
        @(negedge clk); ack_hold = 1'b1;
        clear_log();
        for (int k = 0; k < 4; k++) begin
            step(); i_write_en = 1'b1; i_memaddr = 32'h300 + 4 * k; i_write_data = 32'hB0 + k;
        end
        step(); i_memaddr = 32'h310; i_write_data = 32'hB4;
        @(negedge clk); chk("t3_stall_full", o_stall, 1);
        @(negedge clk); chk("t3_stall_hold", o_stall, 1);
        ack_hold = 1'b0;
        @(negedge clk); chk("t3_stall_before_pop", o_stall, 1);
        @(negedge clk); chk("t3_stall_after_pop", o_stall, 0);
        step(); i_write_en = 1'b0;
        idle_wait(20);
        chk("t3_grants", gl_addr.size(), 5);
        if (gl_addr.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t3_g_addr", gl_addr[k], 32'h300 + 4 * k);
                chk("t3_g_we", gl_we[k], 1);
            end
        end

        // 4: continuous stores starve a pending instruction refill
        clear_log();
        step(); i_write_en = 1'b1; i_memaddr = 32'h400; i_write_data = 32'hC0;
        step(); i_iread_en = 1'b1; i_iaddr = 32'h140;
        n = 1; i_memaddr = 32'h404; i_write_data = 32'hC1;
        got = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            stalled = o_stall;
            if (o_iread_vd) got = 1'b1;
            step();
            if (got) begin
                i_iread_en = 1'b0;
                i_write_en = 1'b0;
            end else if (!stalled) begin
                n++;
                i_memaddr = 32'h400 + 4 * n;
                i_write_data = 32'hC0 + n;
            end
        end
        chk("t4_ivd_seen", got, 1);
        chk("t4_inst", o_inst, 32'h5A5A_0140);
        idle_wait(30);
        chk("t4_enough_grants", gl_addr.size() >= 5, 1);
        if (gl_addr.size() >= 5) begin
            for (int k = 0; k < 4; k++) begin
                chk("t4_w_addr", gl_addr[k], 32'h400 + 4 * k);
                chk("t4_w_we", gl_we[k], 1);
            end
            chk("t4_inst_addr", gl_addr[4], 32'h140);
            chk("t4_inst_we", gl_we[4], 0);
        end

        // 5: reset while a write is outstanding
        @(negedge clk); ack_hold = 1'b1;
        step(); i_write_en = 1'b1; i_memaddr = 32'h500; i_write_data = 32'hD0;
        step(); i_write_en = 1'b0;
        idle_wait(2);
        @(negedge clk); chk("t5_req_busy", o_bus_req, 1);
        step(); rst = 1'b1;
        #1; chk("t5_req_async", o_bus_req, 0);
        step(); step(); rst = 1'b0;
        clear_log();
        @(negedge clk); ack_hold = 1'b0;
        idle_wait(5);
        chk("t5_no_grant", gl_addr.size(), 0);
        base = ivd_cnt + rvd_cnt;
        @(negedge clk); force_req++;
        idle_wait(4);
        chk("t5_no_vd", ivd_cnt + rvd_cnt - base, 0);
        chk("t5_no_grant_after_ack", gl_addr.size(), 0);

        // 6: data read and instruction refill requested together
        clear_log();
        step();
        i_iaddr = 32'h180; i_iread_en = 1'b1;
        i_memaddr = 32'h280; i_read_en = 1'b1;
        gi = 1'b0; gr = 1'b0;
        for (int c = 0; c < 60 && !(gi && gr); c++) begin
            @(negedge clk);
            di = o_iread_vd;
            dr = o_read_vd;
            step();
            if (di) begin gi = 1'b1; i_iread_en = 1'b0; end
            if (dr) begin gr = 1'b1; i_read_en = 1'b0; end
        end
        chk("t6_both_served", gi && gr, 1);
        idle_wait(4);
        chk("t6_grants", gl_addr.size(), 2);
        if (gl_addr.size() >= 2) begin
            chk("t6_first_addr", gl_addr[0], 32'h280);
            chk("t6_first_we", gl_we[0], 0);
            chk("t6_second_addr", gl_addr[1], 32'h180);
        end
        chk("t6_rdata", o_read_data, 32'h5A5A_0280);
        chk("t6_inst", o_inst, 32'h5A5A_0180);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
